ps2_keyboard: RTL
=================

Name: ps2_keyboard

Overview:
- Receives PS/2 keyboard frames on ps2_clk/ps2_data, checks framing and parity, and decodes E0/F0 prefixes into make/break events.
- Keeps held-state flags for the four game keys: two players, gas and gear-shift each.
- Sits between the board PS/2 pins and the game-logic/draw stages in the 65 MHz domain, alongside vga_timing.
- Its outputs are the only source of player input for the race controller.

Parameters:
- CLK_HZ, 65000000, system clock frequency; documentation only, no logic depends on it.
- TIMEOUT_CYC, 65000, idle clock cycles allowed between PS/2 falling edges mid-frame (1 ms at 65 MHz).
- KEY_P1_GAS, 9'h01D, {extended, code} of player-1 gas key (W).
- KEY_P1_SHIFT, 9'h01B, player-1 shift key (S).
- KEY_P2_GAS, 9'h175, player-2 gas key (E0 75, up arrow).
- KEY_P2_SHIFT, 9'h172, player-2 shift key (E0 72, down arrow).

Ports:
- clk  in  1  65 MHz system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- scan_code  out  8  last decoded non-prefix byte.
- scan_ext  out  1  scan_code was preceded by E0.
- scan_brk  out  1  scan_code was preceded by F0 (key release).
- scan_valid  out  1  one-cycle strobe; scan_code, scan_ext and scan_brk are valid while it is high.
- frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout error.
- keys_held  out  4  {P2_SHIFT, P2_GAS, P1_SHIFT, P1_GAS}; 1 = key currently pressed.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0; FSM to IDLE; prefix flags cleared; timeout counter 0.
  - both synchroniser chains preset to 1, so no false edge is seen on release.
- Input conditioning:
  - 2-FF synchroniser on each pin, plus a third register on the clock for edge detect.
  - fall = clk_s2 & ~clk_s1 (previous high, current low), one cycle wide.
  - Data is sampled from the synchronised data pin in the same cycle as fall.
- Frame FSM (advances only on fall):
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE, frame_err pulse (bad start).
  - DATA: shift the bit in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: go to IDLE. Frame is good when stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A bad frame gives frame_err and no byte.
- Timeout:
  - Counter clears on every fall and while in IDLE; otherwise increments.
  - When it reaches TIMEOUT_CYC: FSM -> IDLE, frame_err pulse, prefix flags cleared, no byte.
  - If fall and timeout occur in the same cycle, fall wins and the counter clears.
- Byte decoder (one cycle after a good STOP):
  - 8'hE0: set ext flag, no strobe.
  - 8'hF0: set brk flag, no strobe.
  - Any other byte:
    - drive scan_code/scan_ext/scan_brk from the byte and flags, pulse scan_valid, clear both flags.
    - if {ext, code} matches a KEY_* parameter, set the matching keys_held bit to ~brk in the same cycle as scan_valid.
  - Any frame_err clears both flags; keys_held is unchanged.
- Latency: scan_valid is high exactly 2 clk cycles after the fall strobe for the stop bit, i.e. about 4–5 cycles after the pin edge.
- scan_code/scan_ext/scan_brk hold their values between strobes.
- Typematic repeats re-assert the same keys_held value; this is harmless.
- Host-to-device transmission is out of scope: pins are inputs only.

Decomposition:
- Shared package drag_pkg: constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, the default KEY_* codes, and the keys_held bit indices KEY_IDX_P1_GAS..KEY_IDX_P2_SHIFT for the race controller.
- Sub-module ps2_rx: synchroniser, edge detect, frame FSM and timeout. Outputs rx_byte, rx_valid, rx_err.
- ps2_keyboard contains ps2_rx plus the prefix decoder and key-state registers.

Test Plan:
- Frame 1D (bits 1,0,1,1,1,0,0,0, parity 1) at a 20 µs PS/2 clock period -> scan_valid once, scan_code=1D, ext=0, brk=0, keys_held=4'b0001, no frame_err.
- Sequence F0,1D -> single strobe with scan_code=1D, brk=1; keys_held[0] goes 1 -> 0; no strobe for F0.
- Sequence E0,75 then E0,F0,75 -> first strobe ext=1 brk=0, keys_held=4'b0100; second strobe ext=1 brk=1, keys_held=4'b0000.
- Frame 1B with parity forced to 0 -> frame_err pulse, no scan_valid, keys_held unchanged; next valid 1B frame is decoded normally.
- Stop ps2_clk after 5 data bits for 2 ms -> frame_err at TIMEOUT_CYC; the following full frame 29 is decoded correctly.
- Assert rst in the middle of E0,F0 then send 75 -> after reset, scan_code=75, ext=0, brk=0, since the prefixes were cleared.

Source files
------------

// File: rtl/drag_pkg.sv
// Shared constants for the drag-race input path.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : PS/2 set-2 prefix bytes (E0 / F0).
//   DEF_KEY_*                       : default {extended, code} of the game keys.
//   KEY_IDX_*                       : bit positions inside keys_held.
//   rx_state_t                      : PS/2 frame receiver states.
package drag_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [8:0] DEF_KEY_P1_GAS   = 9'h01D;  // W
  localparam logic [8:0] DEF_KEY_P1_SHIFT = 9'h01B;  // S
  localparam logic [8:0] DEF_KEY_P2_GAS   = 9'h175;  // E0 75, up arrow
  localparam logic [8:0] DEF_KEY_P2_SHIFT = 9'h172;  // E0 72, down arrow

  localparam int unsigned KEY_IDX_P1_GAS   = 0;
  localparam int unsigned KEY_IDX_P1_SHIFT = 1;
  localparam int unsigned KEY_IDX_P2_GAS   = 2;
  localparam int unsigned KEY_IDX_P2_SHIFT = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
//   clk, rst     : system clock, asynchronous active-low reset
//   ps2_clk      : raw PS/2 clock pin (asynchronous)
//   ps2_data     : raw PS/2 data pin (asynchronous)
//   rx_byte      : last good data byte (held)
//   rx_valid     : one-cycle strobe, rx_byte is new
//   rx_err       : one-cycle strobe on bad start/parity/stop or mid-frame timeout
module ps2_rx
  import drag_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity;
  logic [CNT_W-1:0] to_cnt;

  // Chains preset to idle-high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (fall) begin
        // A falling edge always wins over a coincident timeout.
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!data_sync) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end else begin
              rx_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity <= data_sync;
            state  <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (data_sync && (^{shreg, parity})) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state == RX_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == CNT_W'(TIMEOUT_CYC)) begin
        state  <= RX_IDLE;
        to_cnt <= '0;
        rx_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end for the drag-race game.
//   clk, rst   : 65 MHz system clock, asynchronous active-low reset
//   ps2_clk    : raw PS/2 clock pin
//   ps2_data   : raw PS/2 data pin
//   scan_code  : last non-prefix byte (held between strobes)
//   scan_ext   : scan_code was preceded by E0
//   scan_brk   : scan_code was preceded by F0 (release)
//   scan_valid : one-cycle strobe for scan_code/scan_ext/scan_brk
//   frame_err  : one-cycle strobe on any receive error
//   keys_held  : {P2_SHIFT, P2_GAS, P1_SHIFT, P1_GAS}, 1 = pressed
module ps2_keyboard
  import drag_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 65000000,
  parameter int unsigned TIMEOUT_CYC  = 65000,
  parameter logic [8:0]  KEY_P1_GAS   = DEF_KEY_P1_GAS,
  parameter logic [8:0]  KEY_P1_SHIFT = DEF_KEY_P1_SHIFT,
  parameter logic [8:0]  KEY_P2_GAS   = DEF_KEY_P2_GAS,
  parameter logic [8:0]  KEY_P2_SHIFT = DEF_KEY_P2_SHIFT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_brk,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [3:0] keys_held
);

  // Sanity check on parameters; nothing in the datapath depends on CLK_HZ.
  if (CLK_HZ == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("ps2_keyboard: CLK_HZ and TIMEOUT_CYC must be non-zero");
  end

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext_flag;
  logic       brk_flag;
  logic [3:0] key_hit;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_comb begin
    key_hit                   = '0;
    key_hit[KEY_IDX_P1_GAS]   = ({ext_flag, rx_byte} == KEY_P1_GAS);
    key_hit[KEY_IDX_P1_SHIFT] = ({ext_flag, rx_byte} == KEY_P1_SHIFT);
    key_hit[KEY_IDX_P2_GAS]   = ({ext_flag, rx_byte} == KEY_P2_GAS);
    key_hit[KEY_IDX_P2_SHIFT] = ({ext_flag, rx_byte} == KEY_P2_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      scan_code  <= '0;
      scan_ext   <= 1'b0;
      scan_brk   <= 1'b0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      keys_held  <= '0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= rx_err;
      if (rx_err) begin
        // A broken frame may have eaten the byte a prefix belonged to.
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          scan_code  <= rx_byte;
          scan_ext   <= ext_flag;
          scan_brk   <= brk_flag;
          scan_valid <= 1'b1;
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
          for (int unsigned i = 0; i < 4; i++) begin
            if (key_hit[i]) keys_held[i] <= ~brk_flag;
          end
        end
      end
    end
  end

endmodule
